fifo_block_sched: RTL and testbench

FIFO_BLOCK_SCHED -- requirements
Module: fifo_block_sched

---
 rtl/aes_fifo_pkg.sv | 15 +
 rtl/fifo_occ_counter.sv | 25 ++
 rtl/fifo_block_sched.sv | 143 ++++++++++++++
 tb/tb_fifo_block_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_fifo_pkg.sv
// Shared defaults and state encoding for the USB-RX to AES block scheduler.
package aes_fifo_pkg;

  localparam int DEF_NUMBITS     = 8;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_occ_counter.sv
// Saturating up/down counter that mirrors the external FIFO's fill level.
module fifo_occ_counter #(
  parameter int W   = 7,
  parameter int MAX = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && count != MAX_CNT) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_block_sched.sv
// Pulls USB RX bytes through an external FIFO and assembles them into
// fixed-size AES blocks, zero-padding the tail block at end of packet.
module fifo_block_sched
  import aes_fifo_pkg::*;
#(
  parameter int NUMBITS     = DEF_NUMBITS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_valid,
  input  logic [NUMBITS-1:0]             rx_data,
  input  logic                           rx_eop,
  output logic                           rx_ready,
  output logic                           fifo_w_enable,
  output logic [NUMBITS-1:0]             fifo_w_data,
  output logic                           fifo_r_enable,
  input  logic [NUMBITS-1:0]             fifo_r_data,
  input  logic                           fifo_empty,
  input  logic                           fifo_full,
  output logic                           blk_valid,
  output logic [NUMBITS*BLOCK_BYTES-1:0] blk_data,
  output logic [4:0]                     blk_pad,
  input  logic                           blk_ack,
  output logic [6:0]                     occupancy
);

  localparam int             CNT_W   = $clog2(BLOCK_BYTES + 1);
  localparam logic [CNT_W-1:0] BLK_CNT = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [6:0]     BLK_OCC = 7'(BLOCK_BYTES);

  state_t             state, state_nxt;
  logic               flush_pend;
  logic [CNT_W-1:0]   byte_cnt;
  logic               last_byte;

  // rx_ready is forced low while reset is asserted, not just after it.
  assign rx_ready      = !rst && !fifo_full && !flush_pend;
  assign fifo_w_enable = rx_valid && rx_ready;
  assign fifo_w_data   = rx_data;
  assign fifo_r_enable = (state == LOAD) && !fifo_empty;
  assign blk_valid     = (state == HOLD);
  assign last_byte     = fifo_r_enable && (byte_cnt == LAST_CNT);

  fifo_occ_counter #(
    .W   (7),
    .MAX (DEPTH - 1)
  ) u_occ (
    .clk   (clk),
    .rst   (rst),
    .inc   (fifo_w_enable),
    .dec   (fifo_r_enable),
    .count (occupancy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (occupancy >= BLK_OCC || (flush_pend && occupancy != '0)) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (last_byte) begin
          state_nxt = HOLD;
        end else if (flush_pend && fifo_empty && byte_cnt < BLK_CNT) begin
          state_nxt = PAD;
        end
      end
      PAD:  state_nxt = HOLD;
      HOLD: begin
        if (blk_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // End-of-packet latch: blocks further RX until the tail block has drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (fifo_w_enable && rx_eop) begin
      flush_pend <= 1'b1;
    end else if (state == IDLE && occupancy == '0) begin
      flush_pend <= 1'b0;
    end else if (state == HOLD && blk_ack && occupancy == '0) begin
      flush_pend <= 1'b0;
    end
  end

  // Byte slot i lives at the i-th byte from the MSB end of blk_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      blk_data <= '0;
      blk_pad  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (fifo_r_enable) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
              if (byte_cnt == CNT_W'(i)) begin
                blk_data[(BLOCK_BYTES-1-i)*NUMBITS +: NUMBITS] <= fifo_r_data;
              end
            end
            byte_cnt <= byte_cnt + 1'b1;
            if (last_byte) begin
              blk_pad <= '0;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (CNT_W'(i) >= byte_cnt) begin
              blk_data[(BLOCK_BYTES-1-i)*NUMBITS +: NUMBITS] <= '0;
            end
          end
          blk_pad <= 5'(BLK_CNT - byte_cnt);
        end
        HOLD: begin
          if (blk_ack) begin
            byte_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_block_sched.sv
// Directed bench: DUT plus a simple external FIFO, checked against hand-built vectors.
module tb_fifo_block_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         rx_eop;
  logic         rx_ready;
  logic         fifo_w_enable;
  logic [7:0]   fifo_w_data;
  logic         fifo_r_enable;
  logic [7:0]   fifo_r_data;
  logic         fifo_empty;
  logic         fifo_full;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic [4:0]   blk_pad;
  logic         blk_ack;
  logic [6:0]   occupancy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_block_sched dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_eop        (rx_eop),
    .rx_ready      (rx_ready),
    .fifo_w_enable (fifo_w_enable),
    .fifo_w_data   (fifo_w_data),
    .fifo_r_enable (fifo_r_enable),
    .fifo_r_data   (fifo_r_data),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .blk_valid     (blk_valid),
    .blk_data      (blk_data),
    .blk_pad       (blk_pad),
    .blk_ack       (blk_ack),
    .occupancy     (occupancy)
  );

  // External 64-slot FIFO, 63 usable, head word visible before the pop.
  logic [7:0] fmem [64];
  logic [5:0] wp, rp;
  assign fifo_empty  = (wp == rp);
  assign fifo_full   = ((wp + 6'd1) == rp);
  assign fifo_r_data = fmem[rp];

  always @(posedge clk) begin
    if (fifo_w_enable) fmem[wp] <= fifo_w_data;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (fifo_w_enable) wp <= wp + 6'd1;
      if (fifo_r_enable) rp <= rp + 6'd1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_block(input logic [7:0] base);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[(15-i)*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_eop = 1'b0;
    blk_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] base, input int n, input logic eop_last);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = base + 8'(i);
      rx_eop   = eop_last && (i == n - 1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
  endtask

  task automatic wait_blk(input string tag);
    int n = 0;
    while (!blk_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!blk_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_load(input string tag);
    int n = 0;
    while (!fifo_r_enable && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!fifo_r_enable) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic ack();
    blk_ack = 1'b1;
    @(negedge clk);
    blk_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    rx_data = '0;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_eop = 1'b0;
    blk_ack = 1'b0;
    @(negedge clk);
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_r_enable", fifo_r_enable, 0);
    check("rst_blk_data", blk_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rx_ready", rx_ready, 1);

    // Full block 0x00..0x0F; stray ack in IDLE must be ignored.
    send(8'h00, 16, 1'b0);
    ack();
    wait_blk("b16");
    check("b16_data", blk_data, 128'h000102030405060708090A0B0C0D0E0F);
    check("b16_pad", blk_pad, 0);
    check("b16_occ", occupancy, 0);
    ack();
    check("b16_after_ack_valid", blk_valid, 0);

    // Short packet with eop, padded tail.
    send(8'hA1, 5, 1'b1);
    check("eop_rx_ready_low", rx_ready, 0);
    wait_blk("eop");
    check("eop_data", blk_data, {40'hA1A2A3A4A5, 88'h0});
    check("eop_pad", blk_pad, 11);
    check("eop_rx_ready_hold", rx_ready, 0);
    ack();
    check("eop_rx_ready_after_ack", rx_ready, 1);

    // Overfill with block parked in HOLD.
    do_reset();
    accepted = 0;
    for (int k = 0; k < 80; k++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h40 + 8'(k);
      #1;
      if (fifo_w_enable) accepted++;
      if (fifo_full) begin
        check("full_rx_ready", rx_ready, 0);
        check("full_w_enable", fifo_w_enable, 0);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("full_accepted", accepted, 79);
    check("full_occ", occupancy, 63);
    check("full_flag", fifo_full, 1);
    check("full_blk_valid", blk_valid, 1);
    check("full_data", blk_data, mk_block(8'h40));

    // Simultaneous write/read during LOAD keeps occupancy flat.
    do_reset();
    send(8'h60, 16, 1'b0);
    wait_blk("burst_a");
    check("burst_a_data", blk_data, mk_block(8'h60));
    send(8'h80, 20, 1'b0);
    check("burst_occ_pre", occupancy, 20);
    ack();
    wait_load("burst");
    for (int k = 0; k < 16; k++) begin
      rx_valid = 1'b1;
      rx_data  = 8'hC0 + 8'(k);
      @(negedge clk);
      check($sformatf("burst_occ_%0d", k), occupancy, 20);
    end
    rx_valid = 1'b0;
    wait_blk("burst_b");
    check("burst_b_data", blk_data, mk_block(8'h80));
    check("burst_b_pad", blk_pad, 0);

    // 32 bytes with eop on the last: two unpadded blocks.
    do_reset();
    send(8'h20, 32, 1'b1);
    wait_blk("two_1");
    check("two_1_data", blk_data, mk_block(8'h20));
    check("two_1_pad", blk_pad, 0);
    check("two_1_rx_ready", rx_ready, 0);
    ack();
    wait_blk("two_2");
    check("two_2_data", blk_data, mk_block(8'h30));
    check("two_2_pad", blk_pad, 0);
    check("two_2_rx_ready", rx_ready, 0);
    ack();
    check("two_rx_ready_after_ack", rx_ready, 1);

    // Reset in the middle of LOAD discards the partial block.
    do_reset();
    send(8'h50, 16, 1'b0);
    wait_load("mid");
    repeat (7) @(negedge clk);
    check("mid_byte_cnt_pre", dut.byte_cnt, 7);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", blk_valid, 0);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_r_enable", fifo_r_enable, 0);
    check("mid_rst_byte_cnt", dut.byte_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_idle_valid", blk_valid, 0);
    send(8'hE0, 16, 1'b0);
    wait_blk("mid_clean");
    check("mid_clean_data", blk_data, mk_block(8'hE0));
    check("mid_clean_pad", blk_pad, 0);
    ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
